// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared stall-sequencer state encoding and default counter widths.
package cpu_ctrl_pkg;

    localparam int WDT_W_DEF  = 8;
    localparam int PERF_W_DEF = 32;

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_DC_WAIT = 3'd1,
        ST_DC_FIN  = 3'd2,
        ST_IC_WAIT = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    function automatic logic is_wait(input state_t s);
        return (s == ST_DC_WAIT) || (s == ST_IC_WAIT);
    endfunction

endpackage

// File: rtl/stall_delay_line.sv
// stall_delay_line: delayed copies of stall and its rising-edge pulse.
module stall_delay_line (
    input  logic clk,
    input  logic rst_n,
    input  logic stall,
    output logic stall_dly,
    output logic stall_dly2,
    output logic stall_1shot
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_dly  <= 1'b0;
            stall_dly2 <= 1'b0;
        end else begin
            stall_dly  <= stall;
            stall_dly2 <= stall_dly;
        end
    end

    assign stall_1shot = stall & ~stall_dly;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: merges cache misses and halt requests into one pipeline freeze,
// with miss watchdog and stall-cycle counter.
module pipe_stall_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int WDT_W  = WDT_W_DEF,
    parameter int PERF_W = PERF_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dc_miss_req,
    input  logic              dc_fill_done,
    input  logic              ic_miss_req,
    input  logic              ic_fill_done,
    input  logic              cpu_run,
    input  logic              soft_rst_req,
    output logic              stall,
    output logic              stall_1shot,
    output logic              stall_dly,
    output logic              stall_dly2,
    output logic              dc_stall_fin,
    output logic              rst_pipe,
    output logic              stall_timeout,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam logic [WDT_W-1:0] WDT_MAX = '1;

    state_t           state, state_nxt;
    logic             ic_pend, ic_pend_nxt;
    logic [WDT_W-1:0] wdt;
    logic             in_wait, enter_wait;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_RUN;
            ic_pend <= 1'b0;
        end else begin
            state   <= state_nxt;
            ic_pend <= ic_pend_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        ic_pend_nxt = ic_pend;
        if (soft_rst_req) begin
            state_nxt   = ST_RUN;
            ic_pend_nxt = 1'b0;
        end else begin
            case (state)
                ST_RUN:     state_nxt = dc_miss_req ? ST_DC_WAIT : ic_miss_req ? ST_IC_WAIT :
                                        !cpu_run ? ST_HALT : ST_RUN;
                ST_DC_WAIT: begin
                    ic_pend_nxt = ic_pend | ic_miss_req;
                    state_nxt   = dc_fill_done ? ST_DC_FIN : ST_DC_WAIT;
                end
                ST_DC_FIN:  begin
                    ic_pend_nxt = 1'b0;
                    state_nxt   = ic_pend ? ST_IC_WAIT : !cpu_run ? ST_HALT : ST_RUN;
                end
                ST_IC_WAIT: state_nxt = !ic_fill_done ? ST_IC_WAIT : !cpu_run ? ST_HALT : ST_RUN;
                ST_HALT:    state_nxt = cpu_run ? ST_RUN : ST_HALT;
                default:    state_nxt = ST_RUN;
            endcase
        end
    end

    // stall is gated by rst_n so every output reads 0 while reset is held
    always_comb begin
        stall        = rst_n & ((state != ST_RUN) | dc_miss_req | ic_miss_req | ~cpu_run);
        dc_stall_fin = (state == ST_DC_FIN);
    end

    assign in_wait    = is_wait(state);
    assign enter_wait = is_wait(state_nxt) & ~in_wait;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_pipe      <= 1'b0;
            wdt           <= '0;
            stall_timeout <= 1'b0;
            stall_cycles  <= '0;
        end else begin
            rst_pipe     <= soft_rst_req | ((state == ST_HALT) & cpu_run);
            stall_cycles <= stall_cycles + PERF_W'(stall);
            if (soft_rst_req) begin
                wdt           <= '0;
                stall_timeout <= 1'b0;
            end else begin
                if (enter_wait)
                    wdt <= '0;
                else if (in_wait && wdt != WDT_MAX)
                    wdt <= wdt + 1'b1;
                if (in_wait && wdt == WDT_MAX - 1'b1)
                    stall_timeout <= 1'b1;
            end
        end
    end

    stall_delay_line u_dly (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .stall_dly   (stall_dly),
        .stall_dly2  (stall_dly2),
        .stall_1shot (stall_1shot)
    );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed scenarios plus randomized run against a behavioural model.
module tb_pipe_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dc_miss_req = 1'b0, dc_fill_done = 1'b0, ic_miss_req = 1'b0, ic_fill_done = 1'b0;
    logic        cpu_run = 1'b1, soft_rst_req = 1'b0;
    logic        stall, stall_1shot, stall_dly, stall_dly2, dc_stall_fin, rst_pipe, stall_timeout;
    logic [31:0] stall_cycles;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .dc_miss_req   (dc_miss_req),
        .dc_fill_done  (dc_fill_done),
        .ic_miss_req   (ic_miss_req),
        .ic_fill_done  (ic_fill_done),
        .cpu_run       (cpu_run),
        .soft_rst_req  (soft_rst_req),
        .stall         (stall),
        .stall_1shot   (stall_1shot),
        .stall_dly     (stall_dly),
        .stall_dly2    (stall_dly2),
        .dc_stall_fin  (dc_stall_fin),
        .rst_pipe      (rst_pipe),
        .stall_timeout (stall_timeout),
        .stall_cycles  (stall_cycles)
    );

    // Behavioural reference: modes named after the sequencer's documented phases
    localparam int M_RUN = 0, M_DCW = 1, M_DCF = 2, M_ICW = 3, M_HALT = 4;
    int          m_mode, m_len;
    bit          m_pend, m_d1, m_d2, m_rstp, m_to;
    int unsigned m_cyc;

    function automatic bit m_stall();
        return (m_mode != M_RUN) || dc_miss_req || ic_miss_req || !cpu_run;
    endfunction

    task automatic model_reset();
        m_mode = M_RUN; m_len = 0; m_pend = 0; m_d1 = 0; m_d2 = 0; m_rstp = 0; m_to = 0; m_cyc = 0;
    endtask

    task automatic model_advance();
        bit s, cur_w, nxt_w;
        int nxt;
        s = m_stall();
        m_d2 = m_d1;
        m_d1 = s;
        m_cyc += s ? 1 : 0;
        m_rstp = soft_rst_req || (m_mode == M_HALT && cpu_run);
        if (soft_rst_req) begin
            m_mode = M_RUN; m_pend = 0; m_to = 0; m_len = 0;
        end else begin
            nxt = m_mode;
            if (m_mode == M_RUN) nxt = dc_miss_req ? M_DCW : ic_miss_req ? M_ICW : !cpu_run ? M_HALT : M_RUN;
            else if (m_mode == M_DCW) begin
                if (ic_miss_req) m_pend = 1;
                if (dc_fill_done) nxt = M_DCF;
            end else if (m_mode == M_DCF) begin
                nxt = m_pend ? M_ICW : !cpu_run ? M_HALT : M_RUN;
                m_pend = 0;
            end else if (m_mode == M_ICW) begin
                if (ic_fill_done) nxt = cpu_run ? M_RUN : M_HALT;
            end else if (cpu_run) nxt = M_RUN;
            cur_w = (m_mode == M_DCW) || (m_mode == M_ICW);
            nxt_w = (nxt == M_DCW) || (nxt == M_ICW);
            if (nxt_w && !cur_w) m_len = 0;
            else if (cur_w) begin
                if (m_len < 255) m_len++;
                if (m_len == 255) m_to = 1;
            end
            m_mode = nxt;
        end
    endtask

    task automatic idle_inputs();
        dc_miss_req = 0; dc_fill_done = 0; ic_miss_req = 0; ic_fill_done = 0; cpu_run = 1; soft_rst_req = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        dc_miss_req = 1; cpu_run = 0;
        #2;
        vectors++;
        if ({stall, stall_1shot, stall_dly, stall_dly2, dc_stall_fin, rst_pipe, stall_timeout} !== 7'b0 ||
            stall_cycles !== 32'd0) begin
            miscompares++;
            $display("FAIL reset got %b cyc=%0d want 0000000 cyc=0",
                {stall, stall_1shot, stall_dly, stall_dly2, dc_stall_fin, rst_pipe, stall_timeout}, stall_cycles);
        end
        do_reset();
    endtask

    task automatic test_idle();
        do_reset();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            vectors++;
            if ({stall, stall_1shot, dc_stall_fin, rst_pipe} !== 4'b0) begin
                miscompares++;
                $display("FAIL idle c=%0d got %b want 0000", c, {stall, stall_1shot, dc_stall_fin, rst_pipe});
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (stall_cycles !== 32'd0) begin
            miscompares++;
            $display("FAIL idle_count got %0d want 0", stall_cycles);
        end
    endtask

    task automatic test_dc_miss();
        logic [4:0] exp;
        do_reset();
        for (int c = 0; c < 26; c++) begin
            dc_miss_req = (c == 10);
            dc_fill_done = (c == 20);
            @(negedge clk);
            exp = {c >= 10 && c <= 21, c == 10, c >= 11 && c <= 22, c >= 12 && c <= 23, c == 21};
            vectors++;
            if ({stall, stall_1shot, stall_dly, stall_dly2, dc_stall_fin} !== exp) begin
                miscompares++;
                $display("FAIL dc_miss c=%0d got %b want %b", c,
                    {stall, stall_1shot, stall_dly, stall_dly2, dc_stall_fin}, exp);
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (stall_cycles !== 32'd12) begin
            miscompares++;
            $display("FAIL dc_miss_count got %0d want 12", stall_cycles);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            dc_miss_req = (c == 5);
            ic_miss_req = (c >= 5 && c <= 15);
            dc_fill_done = (c == 8);
            ic_fill_done = (c == 15);
            @(negedge clk);
            exp = {c >= 5 && c <= 15, c == 5, c == 9};
            vectors++;
            if ({stall, stall_1shot, dc_stall_fin} !== exp) begin
                miscompares++;
                $display("FAIL back_to_back c=%0d got %b want %b", c, {stall, stall_1shot, dc_stall_fin}, exp);
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        vectors++;
        if (stall_cycles !== 32'd11) begin
            miscompares++;
            $display("FAIL back_to_back_count got %0d want 11", stall_cycles);
        end
    endtask

    task automatic test_halt();
        logic [2:0] exp;
        do_reset();
        for (int c = 0; c < 36; c++) begin
            dc_miss_req = (c == 5);
            dc_fill_done = (c == 12);
            cpu_run = !(c >= 8 && c < 30);
            @(negedge clk);
            exp = {c >= 5 && c <= 30, c == 13, c == 31};
            vectors++;
            if ({stall, dc_stall_fin, rst_pipe} !== exp) begin
                miscompares++;
                $display("FAIL halt c=%0d got %b want %b", c, {stall, dc_stall_fin, rst_pipe}, exp);
            end
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    task automatic test_watchdog();
        logic [2:0] exp;
        do_reset();
        for (int c = 0; c < 316; c++) begin
            dc_miss_req = (c == 2);
            soft_rst_req = (c == 310);
            @(negedge clk);
            exp = {c >= 2 && c <= 310, c >= 258 && c <= 310, c == 311};
            vectors++;
            if ({stall, stall_timeout, rst_pipe} !== exp) begin
                miscompares++;
                $display("FAIL watchdog c=%0d got %b want %b", c, {stall, stall_timeout, rst_pipe}, exp);
            end
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int c = 0; c < 9; c++) begin
            dc_miss_req = (c == 3);
            @(posedge clk); #1;
        end
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        vectors++;
        if ({stall, stall_1shot, stall_dly, stall_dly2, dc_stall_fin, rst_pipe, stall_timeout} !== 7'b0 ||
            stall_cycles !== 32'd0) begin
            miscompares++;
            $display("FAIL async_reset got %b cyc=%0d want 0000000 cyc=0",
                {stall, stall_1shot, stall_dly, stall_dly2, dc_stall_fin, rst_pipe, stall_timeout}, stall_cycles);
        end
        @(posedge clk); #1 rst_n = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if ({stall, dc_stall_fin, rst_pipe, stall_timeout} !== 4'b0 || stall_cycles !== 32'd0) begin
                miscompares++;
                $display("FAIL async_release c=%0d got %b cyc=%0d want 0000 cyc=0", c,
                    {stall, dc_stall_fin, rst_pipe, stall_timeout}, stall_cycles);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        logic [6:0] got, exp;
        do_reset();
        model_reset();
        for (int c = 0; c < 4000; c++) begin
            dc_miss_req  = ($urandom_range(7) == 0);
            ic_miss_req  = ($urandom_range(7) == 0);
            dc_fill_done = ($urandom_range(3) == 0);
            ic_fill_done = ($urandom_range(3) == 0);
            cpu_run      = ($urandom_range(9) != 0);
            soft_rst_req = ($urandom_range(63) == 0);
            @(negedge clk);
            got = {stall, stall_1shot, stall_dly, stall_dly2, dc_stall_fin, rst_pipe, stall_timeout};
            exp = {m_stall(), m_stall() && !m_d1, m_d1, m_d2, m_mode == M_DCF, m_rstp, m_to};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL random c=%0d got %b want %b", c, got, exp);
            end
            vectors++;
            if (stall_cycles !== m_cyc) begin
                miscompares++;
                $display("FAIL random_count c=%0d got %0d want %0d", c, stall_cycles, m_cyc);
            end
            @(posedge clk);
            model_advance();
            #1;
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_idle();
        test_dc_miss();
        test_back_to_back();
        test_halt();
        test_watchdog();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
